ro_puf_sequencer: RTL

RO_PUF_SEQUENCER -- requirements
Module: ro_puf_sequencer

---
 rtl/ro_puf_sequencer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/ro_puf_sequencer.sv
// Ring-oscillator PUF sequencer: races oscillator pairs picked from a challenge and builds one response bit per race.
// Latency: per bit CLR_CYC + 1 + race_cycles + STOP_CYC + 1 cycles, plus one FIN cycle that carries done.
// Backpressure: none; start is honoured only in IDLE and is silently dropped otherwise (no queueing).
module ro_puf_sequencer #(
    parameter int N_BITS   = 8,
    parameter int CNT_W    = 4,
    parameter int SEL_W    = 3,
    parameter int CLR_CYC  = 2,
    parameter int STOP_CYC = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SEL_W-1:0]  challenge,
    input  logic [CNT_W-1:0]  count1,
    input  logic [CNT_W-1:0]  count2,
    output logic [SEL_W-1:0]  sel_a,
    output logic [SEL_W-1:0]  sel_b,
    output logic              cnt_reset,
    output logic              cnt_en,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] response,
    output logic              tie_flag,
    output logic              timeout_flag
);

    // Widths of the internal counters.
    localparam int K_W    = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int PH_MAX = (CLR_CYC > STOP_CYC) ? CLR_CYC : STOP_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int RC_W   = $clog2(TIMEOUT + 1);

    // Terminal values, pre-sized so the comparisons below stay width-exact.
    localparam logic [PH_W-1:0]  CLR_LAST  = PH_W'(CLR_CYC - 1);
    localparam logic [PH_W-1:0]  STOP_LAST = PH_W'(STOP_CYC - 1);
    localparam logic [RC_W-1:0]  RACE_LAST = RC_W'(TIMEOUT - 1);
    localparam logic [K_W-1:0]   K_LAST    = K_W'(N_BITS - 1);
    localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);
    localparam logic [RC_W-1:0]  RC_ONE    = RC_W'(1);
    localparam logic [K_W-1:0]   K_ONE     = K_W'(1);
    localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_SETTLE = 3'd2,
        S_RACE   = 3'd3,
        S_STOP   = 3'd4,
        S_CMP    = 3'd5,
        S_FIN    = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     cyc_cnt_q, cyc_cnt_d;
    logic [RC_W-1:0]     race_cnt_q, race_cnt_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [SEL_W-1:0]    chal_q, chal_d;
    logic [SEL_W-1:0]    sel_a_q, sel_a_d;
    logic [SEL_W-1:0]    sel_b_q, sel_b_d;
    logic [N_BITS-1:0]   response_q, response_d;
    logic                tie_q, tie_d;
    logic                timeout_q, timeout_d;

    // Synchronizer stages for signals coming from the oscillator domains.
    logic                sat_raw;
    logic                sat_s1_q, sat_s2_q;
    logic [CNT_W-1:0]    c1_s1_q, c1_s2_q;
    logic [CNT_W-1:0]    c2_s1_q, c2_s2_q;
    logic [K_W-1:0]      k_inc;

    // Either counter reaching all-ones means the race has a winner.
    assign sat_raw = (&count1) | (&count2);
    assign k_inc   = k_q + K_ONE;

    // Two-flop synchronizers; the count copies are only trusted in CMP, once the counters are frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_s1_q <= 1'b0;
            sat_s2_q <= 1'b0;
            c1_s1_q  <= '0;
            c1_s2_q  <= '0;
            c2_s1_q  <= '0;
            c2_s2_q  <= '0;
        end else begin
            sat_s1_q <= sat_raw;
            sat_s2_q <= sat_s1_q;
            c1_s1_q  <= count1;
            c1_s2_q  <= c1_s1_q;
            c2_s1_q  <= count2;
            c2_s2_q  <= c2_s1_q;
        end
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cyc_cnt_q  <= '0;
            race_cnt_q <= '0;
            k_q        <= '0;
            chal_q     <= '0;
            sel_a_q    <= '0;
            sel_b_q    <= '0;
            response_q <= '0;
            tie_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_cnt_q  <= cyc_cnt_d;
            race_cnt_q <= race_cnt_d;
            k_q        <= k_d;
            chal_q     <= chal_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            response_q <= response_d;
            tie_q      <= tie_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state, phase timing, bit evaluation and counter controls.
    always_comb begin
        state_d    = state_q;
        cyc_cnt_d  = cyc_cnt_q;
        race_cnt_d = race_cnt_q;
        k_d        = k_q;
        chal_d     = chal_q;
        sel_a_d    = sel_a_q;
        sel_b_d    = sel_b_q;
        response_d = response_q;
        tie_d      = tie_q;
        timeout_d  = timeout_q;
        cnt_reset  = 1'b0;
        cnt_en     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Counters are held cleared while waiting for work.
                busy      = 1'b0;
                cnt_reset = 1'b1;
                if (start) begin
                    state_d    = S_CLR;
                    chal_d     = challenge;
                    k_d        = '0;
                    response_d = '0;
                    tie_d      = 1'b0;
                    timeout_d  = 1'b0;
                    cyc_cnt_d  = '0;
                    sel_a_d    = challenge;
                    sel_b_d    = challenge + SEL_ONE;
                end
            end

            S_CLR: begin
                cnt_reset = 1'b1;
                if (cyc_cnt_q == CLR_LAST) begin
                    state_d   = S_SETTLE;
                    cyc_cnt_d = '0;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + PH_ONE;
                end
            end

            S_SETTLE: begin
                // One quiet cycle so the cleared counters are stable before enabling.
                state_d    = S_RACE;
                race_cnt_d = '0;
            end

            S_RACE: begin
                cnt_en = 1'b1;
                if (sat_s2_q) begin
                    // A saturation seen together with the last allowed cycle is a normal finish.
                    state_d   = S_STOP;
                    cyc_cnt_d = '0;
                end else if (race_cnt_q == RACE_LAST) begin
                    state_d   = S_STOP;
                    cyc_cnt_d = '0;
                    timeout_d = 1'b1;
                end else begin
                    race_cnt_d = race_cnt_q + RC_ONE;
                end
            end

            S_STOP: begin
                // Wait long enough for the frozen counts to pass through the synchronizers.
                if (cyc_cnt_q == STOP_LAST) begin
                    state_d   = S_CMP;
                    cyc_cnt_d = '0;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + PH_ONE;
                end
            end

            S_CMP: begin
                response_d[k_q] = (c1_s2_q > c2_s2_q);
                if (c1_s2_q == c2_s2_q) begin
                    tie_d = 1'b1;
                end
                if (k_q == K_LAST) begin
                    state_d = S_FIN;
                end else begin
                    // Next pair is selected on the way back into CLR, wrapping modulo the oscillator count.
                    state_d   = S_CLR;
                    k_d       = k_inc;
                    cyc_cnt_d = '0;
                    sel_a_d   = chal_q + SEL_W'(k_inc);
                    sel_b_d   = chal_q + SEL_W'(k_inc) + SEL_ONE;
                end
            end

            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sel_a        = sel_a_q;
    assign sel_b        = sel_b_q;
    assign response     = response_q;
    assign tie_flag     = tie_q;
    assign timeout_flag = timeout_q;

endmodule
